// File: rtl/vram_arb_if.sv
// vram_arb_if: single-port VRAM bus between the arbiter (master) and the memory (slave).
interface vram_arb_if;
  logic        sel;
  logic        wr_en;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  modport master (output sel, wr_en, addr, wdata, input rdata);
  modport slave  (input sel, wr_en, addr, wdata, output rdata);
endinterface

// File: rtl/vram_arb.sv
// vram_arb: fixed-priority arbiter (video > host > fill engine) onto a 1-cycle-latency VRAM port.
module vram_arb #(
  parameter int FILL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vid_sel_i,
  input  logic [15:0]           vid_addr_i,
  output logic                  vid_rd_valid_o,
  output logic [15:0]           vid_rd_data_o,
  input  logic                  host_req_i,
  input  logic                  host_wr_i,
  input  logic [15:0]           host_addr_i,
  input  logic [15:0]           host_wdata_i,
  output logic                  host_ack_o,
  output logic                  host_rd_valid_o,
  output logic [15:0]           host_rd_data_o,
  input  logic                  fill_start_i,
  input  logic                  fill_abort_i,
  input  logic [15:0]           fill_addr_i,
  input  logic [15:0]           fill_incr_i,
  input  logic [FILL_CNT_W-1:0] fill_count_i,
  input  logic [15:0]           fill_data_i,
  output logic                  fill_busy_o,
  output logic                  fill_done_o,
  vram_arb_if.master            vram
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state_q, state_d;
  logic [15:0]           ptr_q, ptr_d, vid_data_q, host_data_q;
  logic [FILL_CNT_W-1:0] rem_q, rem_d;
  logic                  zero_q, zero_d, vid_tag_q, host_tag_q, host_g, fill_g;
  assign host_g = host_req_i & ~vid_sel_i;
  assign fill_g = ~vid_sel_i & ~host_req_i & (state_q == RUN);
  // rst_n gates only the bus strobes so the flops never see it as a data input
  always_comb begin
    vram.sel   = rst_n & (vid_sel_i | host_req_i | fill_g);
    vram.wr_en = rst_n & ((host_g & host_wr_i) | fill_g);
    vram.addr  = vid_sel_i ? vid_addr_i : host_g ? host_addr_i : fill_g ? ptr_q : 16'h0;
    vram.wdata = host_g ? host_wdata_i : fill_g ? fill_data_i : 16'h0;
    host_ack_o = rst_n & host_g;
  end
  assign vid_rd_valid_o  = vid_tag_q;
  assign host_rd_valid_o = host_tag_q;
  assign vid_rd_data_o   = vid_tag_q ? vram.rdata : vid_data_q;
  assign host_rd_data_o  = host_tag_q ? vram.rdata : host_data_q;
  assign fill_busy_o     = state_q != IDLE;
  assign fill_done_o     = (state_q == DONE) | zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      zero_q      <= 1'b0;
      vid_tag_q   <= 1'b0;
      host_tag_q  <= 1'b0;
      vid_data_q  <= '0;
      host_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      zero_q      <= zero_d;
      vid_tag_q   <= vid_sel_i;
      host_tag_q  <= host_g & ~host_wr_i;
      vid_data_q  <= vid_rd_data_o;
      host_data_q <= host_rd_data_o;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: if (fill_start_i) begin
        zero_d  = fill_count_i == '0;
        ptr_d   = fill_addr_i;
        rem_d   = fill_count_i;
        state_d = (fill_count_i == '0) ? IDLE : RUN;
      end
      RUN: begin
        if (fill_g) begin
          ptr_d = ptr_q + fill_incr_i;
          rem_d = rem_q - 1'b1;
        end
        if ((fill_g && rem_q == FILL_CNT_W'(1)) || fill_abort_i) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: directed tests of vram_arb against a stub 64K x 16 VRAM with 1-cycle read latency.
module tb_vram_arb;
  logic        clk, rst_n;
  logic        vid_sel, vid_rd_valid, host_req, host_wr, host_ack, host_rd_valid;
  logic        fill_start, fill_abort, fill_busy, fill_done;
  logic [15:0] vid_addr, vid_rd_data, host_addr, host_wdata, host_rd_data;
  logic [15:0] fill_addr, fill_incr, fill_count, fill_data;
  logic [15:0] mem [0:65535];
  int          checks = 0, failures = 0;
  vram_arb_if vif ();
  vram_arb #(.FILL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_sel_i(vid_sel), .vid_addr_i(vid_addr), .vid_rd_valid_o(vid_rd_valid), .vid_rd_data_o(vid_rd_data),
    .host_req_i(host_req), .host_wr_i(host_wr), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_ack_o(host_ack), .host_rd_valid_o(host_rd_valid), .host_rd_data_o(host_rd_data),
    .fill_start_i(fill_start), .fill_abort_i(fill_abort), .fill_addr_i(fill_addr), .fill_incr_i(fill_incr),
    .fill_count_i(fill_count), .fill_data_i(fill_data), .fill_busy_o(fill_busy), .fill_done_o(fill_done),
    .vram(vif)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (vif.sel && vif.wr_en) mem[vif.addr] <= vif.wdata;
    if (vif.sel && !vif.wr_en) vif.rdata <= mem[vif.addr];
  end
  task automatic test_reset();
    rst_n = 1'b0; vid_sel = 1'b1; host_req = 1'b1; host_wr = 1'b1;
    vid_addr = 16'h0; host_addr = 16'h0; host_wdata = 16'h0;
    fill_start = 1'b0; fill_abort = 1'b0; fill_addr = 16'h0; fill_incr = 16'h0; fill_count = 16'h0; fill_data = 16'h0;
    #1;
    checks++; if (vif.sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", vif.sel); end
    checks++; if (vif.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", vif.wr_en); end
    checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", host_ack); end
    checks++; if ({vid_rd_valid, host_rd_valid, fill_busy, fill_done} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {vid_rd_valid, host_rd_valid, fill_busy, fill_done}); end
    checks++; if ({vid_rd_data, host_rd_data} !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {vid_rd_data, host_rd_data}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; vid_sel = 1'b0; host_req = 1'b0;
  endtask
  task automatic test_video_priority();
    @(negedge clk); host_req = 1'b1; host_wr = 1'b1; host_addr = 16'hF000; host_wdata = 16'hCAFE; #1;
    checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL vp_preload_ack got=%b exp=1", host_ack); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vid_sel = (i < 4); vid_addr = 16'hF000; host_addr = 16'h0200; host_wdata = 16'hBEEF; #1;
      checks++; if (host_ack !== (i == 4)) begin failures++; $display("FAIL vp_ack[%0d] got=%b exp=%b", i, host_ack, i == 4); end
      checks++; if (vid_rd_valid !== (i > 0)) begin failures++; $display("FAIL vp_valid[%0d] got=%b exp=%b", i, vid_rd_valid, i > 0); end
      if (i > 0) begin
        checks++; if (vid_rd_data !== 16'hCAFE) begin failures++; $display("FAIL vp_data[%0d] got=%h exp=cafe", i, vid_rd_data); end
      end
      if (i < 4) begin
        checks++; if ({vif.sel, vif.wr_en, vif.addr} !== {2'b10, 16'hF000}) begin failures++; $display("FAIL vp_bus[%0d] got=%b%b/%h exp=10/f000", i, vif.sel, vif.wr_en, vif.addr); end
      end else begin
        checks++; if ({vif.sel, vif.wr_en, vif.addr, vif.wdata} !== {2'b11, 16'h0200, 16'hBEEF}) begin failures++; $display("FAIL vp_hostwr got=%b%b/%h/%h exp=11/0200/beef", vif.sel, vif.wr_en, vif.addr, vif.wdata); end
      end
    end
    @(negedge clk); host_req = 1'b0; #1;
    checks++; if ({vid_rd_valid, host_rd_valid} !== 2'b00) begin failures++; $display("FAIL vp_after got=%b exp=00", {vid_rd_valid, host_rd_valid}); end
  endtask
  task automatic test_host_rw();
    @(negedge clk); host_req = 1'b1; host_wr = 1'b1; host_addr = 16'h0100; host_wdata = 16'h1234; #1;
    checks++; if ({host_ack, vif.wr_en} !== 2'b11) begin failures++; $display("FAIL hrw_wr got=%b exp=11", {host_ack, vif.wr_en}); end
    @(negedge clk); host_wr = 1'b0; #1;
    checks++; if ({host_ack, vif.sel, vif.wr_en} !== 3'b110) begin failures++; $display("FAIL hrw_rd got=%b exp=110", {host_ack, vif.sel, vif.wr_en}); end
    checks++; if (host_rd_valid !== 1'b0) begin failures++; $display("FAIL hrw_wr_novalid got=%b exp=0", host_rd_valid); end
    @(negedge clk); host_req = 1'b0; #1;
    checks++; if ({host_rd_valid, vid_rd_valid} !== 2'b10) begin failures++; $display("FAIL hrw_valid got=%b exp=10", {host_rd_valid, vid_rd_valid}); end
    checks++; if (host_rd_data !== 16'h1234) begin failures++; $display("FAIL hrw_data got=%h exp=1234", host_rd_data); end
    @(negedge clk); #1;
    checks++; if ({host_rd_valid, host_rd_data} !== {1'b0, 16'h1234}) begin failures++; $display("FAIL hrw_hold got=%b/%h exp=0/1234", host_rd_valid, host_rd_data); end
  endtask
  task automatic test_fill_wrap();
    logic [15:0] ea;
    ea = 16'hFFFE;
    @(negedge clk); fill_start = 1'b1; fill_addr = 16'hFFFE; fill_incr = 16'h1; fill_count = 16'd4; fill_data = 16'hA5A5; #1;
    checks++; if (vif.sel !== 1'b0) begin failures++; $display("FAIL fw_start_sel got=%b exp=0", vif.sel); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); fill_start = 1'b0; #1;
      checks++; if ({vif.sel, vif.wr_en, vif.addr, vif.wdata} !== {2'b11, ea, 16'hA5A5}) begin failures++; $display("FAIL fw_write[%0d] got=%b%b/%h/%h exp=11/%h/a5a5", i, vif.sel, vif.wr_en, vif.addr, vif.wdata, ea); end
      checks++; if ({fill_busy, fill_done} !== 2'b10) begin failures++; $display("FAIL fw_busy[%0d] got=%b exp=10", i, {fill_busy, fill_done}); end
      ea = ea + 16'h1;
    end
    @(negedge clk); #1;
    checks++; if ({vif.sel, fill_busy, fill_done} !== 3'b011) begin failures++; $display("FAIL fw_done got=%b exp=011", {vif.sel, fill_busy, fill_done}); end
    @(negedge clk); #1;
    checks++; if ({vif.sel, fill_busy, fill_done} !== 3'b000) begin failures++; $display("FAIL fw_idle got=%b exp=000", {vif.sel, fill_busy, fill_done}); end
  endtask
  task automatic test_fill_contention();
    logic [15:0] ea;
    int n, done_c;
    ea = 16'h1000; n = 0; done_c = 0;
    @(negedge clk); fill_start = 1'b1; fill_addr = 16'h1000; fill_incr = 16'h2; fill_count = 16'd8; fill_data = 16'h5A5A;
    host_wr = 1'b0; host_addr = 16'h0100;
    for (int c = 1; c <= 20 && done_c == 0; c++) begin
      @(negedge clk); fill_start = 1'b0; host_req = (c == 2 || c == 3); vid_sel = (c == 5); vid_addr = 16'h0100; #1;
      if (fill_done) done_c = c;
      if (c == 2 || c == 3 || c == 5) begin
        checks++; if ({vif.wr_en, host_ack} !== {1'b0, c != 5}) begin failures++; $display("FAIL fc_stall[%0d] got=%b exp=0%b", c, {vif.wr_en, host_ack}, c != 5); end
      end else if (vif.sel && vif.wr_en) begin
        checks++; if ({vif.addr, vif.wdata} !== {ea, 16'h5A5A}) begin failures++; $display("FAIL fc_write[%0d] got=%h/%h exp=%h/5a5a", c, vif.addr, vif.wdata, ea); end
        ea = ea + 16'h2; n++;
      end
    end
    host_req = 1'b0; vid_sel = 1'b0;
    checks++; if (n !== 8) begin failures++; $display("FAIL fc_count got=%0d exp=8", n); end
    checks++; if (done_c !== 12) begin failures++; $display("FAIL fc_done_cycle got=%0d exp=12", done_c); end
    @(negedge clk); #1;
    checks++; if ({fill_busy, fill_done} !== 2'b00) begin failures++; $display("FAIL fc_idle got=%b exp=00", {fill_busy, fill_done}); end
  endtask
  task automatic test_fill_zero_busy();
    @(negedge clk); fill_start = 1'b1; fill_count = 16'd0; fill_addr = 16'h7000; #1;
    checks++; if (vif.sel !== 1'b0) begin failures++; $display("FAIL fz_sel got=%b exp=0", vif.sel); end
    @(negedge clk); fill_start = 1'b0; #1;
    checks++; if ({vif.sel, fill_busy, fill_done} !== 3'b001) begin failures++; $display("FAIL fz_done got=%b exp=001", {vif.sel, fill_busy, fill_done}); end
    @(negedge clk); #1;
    checks++; if (fill_done !== 1'b0) begin failures++; $display("FAIL fz_pulse got=%b exp=0", fill_done); end
    fill_start = 1'b1; fill_count = 16'd3; fill_addr = 16'h2000; fill_incr = 16'h1;
    @(negedge clk); fill_addr = 16'h3000; fill_count = 16'd5; #1;
    checks++; if ({vif.wr_en, vif.addr} !== {1'b1, 16'h2000}) begin failures++; $display("FAIL fb_w0 got=%b/%h exp=1/2000", vif.wr_en, vif.addr); end
    @(negedge clk); #1;
    checks++; if ({vif.wr_en, vif.addr} !== {1'b1, 16'h2001}) begin failures++; $display("FAIL fb_w1 got=%b/%h exp=1/2001", vif.wr_en, vif.addr); end
    @(negedge clk); fill_start = 1'b0; #1;
    checks++; if ({vif.wr_en, vif.addr} !== {1'b1, 16'h2002}) begin failures++; $display("FAIL fb_w2 got=%b/%h exp=1/2002", vif.wr_en, vif.addr); end
    @(negedge clk); #1;
    checks++; if ({vif.sel, fill_done} !== 2'b01) begin failures++; $display("FAIL fb_done got=%b exp=01", {vif.sel, fill_done}); end
    @(negedge clk);
  endtask
  task automatic test_abort_reset();
    @(negedge clk); fill_start = 1'b1; fill_count = 16'd10; fill_addr = 16'h4000; fill_incr = 16'h1;
    @(negedge clk); fill_start = 1'b0;
    @(negedge clk); fill_abort = 1'b1; #1;
    checks++; if ({vif.wr_en, vif.addr} !== {1'b1, 16'h4001}) begin failures++; $display("FAIL ab_last got=%b/%h exp=1/4001", vif.wr_en, vif.addr); end
    @(negedge clk); fill_abort = 1'b0; #1;
    checks++; if ({vif.sel, fill_busy, fill_done} !== 3'b011) begin failures++; $display("FAIL ab_done got=%b exp=011", {vif.sel, fill_busy, fill_done}); end
    @(negedge clk); #1;
    checks++; if ({vif.sel, fill_busy, fill_done} !== 3'b000) begin failures++; $display("FAIL ab_idle got=%b exp=000", {vif.sel, fill_busy, fill_done}); end
    fill_start = 1'b1; fill_addr = 16'h5000;
    @(negedge clk); fill_start = 1'b0; #1;
    checks++; if ({vif.wr_en, vif.addr, fill_busy} !== {1'b1, 16'h5000, 1'b1}) begin failures++; $display("FAIL rs_run got=%b/%h/%b exp=1/5000/1", vif.wr_en, vif.addr, fill_busy); end
    #1 rst_n = 1'b0; #1;
    checks++; if ({vif.sel, vif.wr_en, host_ack, fill_busy, fill_done} !== 5'b0) begin failures++; $display("FAIL rs_async got=%b exp=00000", {vif.sel, vif.wr_en, host_ack, fill_busy, fill_done}); end
    checks++; if ({vid_rd_valid, host_rd_valid, vid_rd_data, host_rd_data} !== 34'h0) begin failures++; $display("FAIL rs_rd got=%h exp=0", {vid_rd_valid, host_rd_valid, vid_rd_data, host_rd_data}); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1; #1;
    checks++; if ({vif.sel, fill_busy, fill_done} !== 3'b000) begin failures++; $display("FAIL rs_rel got=%b exp=000", {vif.sel, fill_busy, fill_done}); end
    @(negedge clk); #1;
    checks++; if ({vif.sel, fill_busy, fill_done} !== 3'b000) begin failures++; $display("FAIL rs_nodone got=%b exp=000", {vif.sel, fill_busy, fill_done}); end
  endtask
  initial begin
    test_reset();
    test_video_priority();
    test_host_rw();
    test_fill_wrap();
    test_fill_contention();
    test_fill_zero_busy();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
